// File: rtl/hsv_colour_bbox.sv
// hsv_colour_bbox: thresholds an HSV pixel stream against a hue/sat/value window, emits a per-pixel mask and reports the per-frame bounding box and match count
// Ports: clk, rst (async active-high); hsv_h/hsv_s/hsv_v + valid_in/sop/eop pixel stream;
//        h_min/h_max/s_min/v_min runtime window; mask/mask_valid per-pixel result;
//        bbox_valid/bbox_found/x_min/x_max/y_min/y_max/pix_count per-frame report.
module hsv_colour_bbox #(
  parameter int IMAGE_W = 640,
  parameter int IMAGE_H = 480,
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int CNT_W   = 19,
  parameter int MIN_PIX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [8:0]       hsv_h,
  input  logic [7:0]       hsv_s,
  input  logic [7:0]       hsv_v,
  input  logic             valid_in,
  input  logic             sop,
  input  logic             eop,
  input  logic [8:0]       h_min,
  input  logic [8:0]       h_max,
  input  logic [7:0]       s_min,
  input  logic [7:0]       v_min,
  output logic             mask,
  output logic             mask_valid,
  output logic             bbox_valid,
  output logic             bbox_found,
  output logic [X_W-1:0]   x_min,
  output logic [X_W-1:0]   x_max,
  output logic [Y_W-1:0]   y_min,
  output logic [Y_W-1:0]   y_max,
  output logic [CNT_W-1:0] pix_count
);
  localparam logic [X_W-1:0]   X_LAST  = X_W'(IMAGE_W - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(IMAGE_H - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIX);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;
  logic acc;
  logic [X_W-1:0] x_q, cx;
  logic [Y_W-1:0] y_q, cy;
  logic [8:0] hmin_q, hmax_q, hl, hh;
  logic [7:0] smin_q, vmin_q, sl, vl;
  logic hue_ok, match;
  logic mask_q, mv_q, sp_q, ep_q;
  logic [X_W-1:0] xp_q;
  logic [Y_W-1:0] yp_q;
  logic any_q, any_d, b_any, hit, report;
  logic [X_W-1:0] xmin_q, xmax_q, xmin_d, xmax_d;
  logic [Y_W-1:0] ymin_q, ymax_q, ymin_d, ymax_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, b_cnt;
  logic bv_q, found_q;
  logic [X_W-1:0] x_min_q, x_max_q;
  logic [Y_W-1:0] y_min_q, y_max_q;
  logic [CNT_W-1:0] pc_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (valid_in) state_d = eop ? IDLE : (sop ? ACTIVE : state_q);
  end
  always_comb acc = valid_in & (sop | (state_q == ACTIVE));
  // A sop beat starts at (0,0) and is judged against the live window it captures.
  always_comb begin
    cx = sop ? '0 : x_q;
    cy = sop ? '0 : y_q;
    hl = sop ? h_min : hmin_q;
    hh = sop ? h_max : hmax_q;
    sl = sop ? s_min : smin_q;
    vl = sop ? v_min : vmin_q;
    hue_ok = (hl <= hh) ? (hsv_h >= hl && hsv_h <= hh) : (hsv_h >= hl || hsv_h <= hh);
    match = hue_ok && hsv_s >= sl && hsv_v >= vl;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      hmin_q <= '0;
      hmax_q <= '0;
      smin_q <= '0;
      vmin_q <= '0;
      mask_q <= 1'b0;
      mv_q <= 1'b0;
      sp_q <= 1'b0;
      ep_q <= 1'b0;
      xp_q <= '0;
      yp_q <= '0;
    end else begin
      mask_q <= acc & match;
      mv_q <= acc;
      sp_q <= acc & sop;
      ep_q <= acc & eop;
      xp_q <= cx;
      yp_q <= cy;
      if (acc) begin
        x_q <= (cx == X_LAST) ? '0 : cx + 1'b1;
        y_q <= (cx == X_LAST && cy != Y_LAST) ? cy + 1'b1 : cy;
      end
      if (acc & sop) begin
        hmin_q <= h_min;
        hmax_q <= h_max;
        smin_q <= s_min;
        vmin_q <= v_min;
      end
    end
  // A registered sop pixel discards whatever an abandoned frame left behind.
  always_comb begin
    b_any = ~sp_q & any_q;
    b_cnt = sp_q ? '0 : cnt_q;
    hit = mv_q & mask_q;
    any_d = b_any | hit;
    xmin_d = (hit && (!b_any || xp_q < xmin_q)) ? xp_q : xmin_q;
    xmax_d = (hit && (!b_any || xp_q > xmax_q)) ? xp_q : xmax_q;
    ymin_d = (hit && (!b_any || yp_q < ymin_q)) ? yp_q : ymin_q;
    ymax_d = (hit && (!b_any || yp_q > ymax_q)) ? yp_q : ymax_q;
    cnt_d = (hit && b_cnt != CNT_MAX) ? b_cnt + 1'b1 : b_cnt;
    report = mv_q & ep_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      any_q <= 1'b0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      cnt_q <= '0;
      bv_q <= 1'b0;
      found_q <= 1'b0;
      x_min_q <= '0;
      x_max_q <= '0;
      y_min_q <= '0;
      y_max_q <= '0;
      pc_q <= '0;
    end else begin
      bv_q <= report;
      if (report) begin
        found_q <= cnt_d >= MIN_CNT;
        x_min_q <= (cnt_d >= MIN_CNT) ? xmin_d : '0;
        x_max_q <= (cnt_d >= MIN_CNT) ? xmax_d : '0;
        y_min_q <= (cnt_d >= MIN_CNT) ? ymin_d : '0;
        y_max_q <= (cnt_d >= MIN_CNT) ? ymax_d : '0;
        pc_q <= cnt_d;
        any_q <= 1'b0;
        cnt_q <= '0;
      end else if (mv_q) begin
        any_q <= any_d;
        xmin_q <= xmin_d;
        xmax_q <= xmax_d;
        ymin_q <= ymin_d;
        ymax_q <= ymax_d;
        cnt_q <= cnt_d;
      end
    end
  assign mask = mask_q;
  assign mask_valid = mv_q;
  assign bbox_valid = bv_q;
  assign bbox_found = found_q;
  assign x_min = x_min_q;
  assign x_max = x_max_q;
  assign y_min = y_min_q;
  assign y_max = y_max_q;
  assign pix_count = pc_q;
endmodule

// File: tb/tb_hsv_colour_bbox.sv
// tb_hsv_colour_bbox: directed self-checking bench for hsv_colour_bbox on an 8x4 image
module tb_hsv_colour_bbox;
  logic clk = 1'b0;
  logic rst;
  logic [8:0] hsv_h, h_min, h_max;
  logic [7:0] hsv_s, hsv_v, s_min, v_min;
  logic valid_in, sop, eop;
  logic mask, mask_valid, bbox_valid, bbox_found;
  logic [9:0] x_min, x_max;
  logic [8:0] y_min, y_max;
  logic [18:0] pix_count;
  int checks = 0;
  int failures = 0;
  logic pv = 1'b0, pm = 1'b0, pe1 = 1'b0, pe2 = 1'b0;
  hsv_colour_bbox #(.IMAGE_W(8), .IMAGE_H(4), .MIN_PIX(2)) dut (
    .clk(clk), .rst(rst), .hsv_h(hsv_h), .hsv_s(hsv_s), .hsv_v(hsv_v),
    .valid_in(valid_in), .sop(sop), .eop(eop),
    .h_min(h_min), .h_max(h_max), .s_min(s_min), .v_min(v_min),
    .mask(mask), .mask_valid(mask_valid), .bbox_valid(bbox_valid), .bbox_found(bbox_found),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max), .pix_count(pix_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Each step checks the mask of the previous beat and bbox_valid for the eop two beats back.
  task automatic step(input logic v, input logic a, input logic sp, input logic ep,
                      input logic [8:0] h, input logic [7:0] s, input logic [7:0] vv, input logic m);
    @(negedge clk);
    chk("mask_valid", mask_valid, pv);
    if (pv) chk("mask", mask, pm);
    chk("bbox_valid", bbox_valid, pe2);
    pe2 = pe1;
    pe1 = a & ep;
    pv = a;
    pm = m;
    valid_in = v;
    sop = sp;
    eop = ep;
    hsv_h = h;
    hsv_s = s;
    hsv_v = vv;
  endtask
  task automatic beat(input logic sp, input logic ep, input logic [8:0] h, input logic m);
    step(1'b1, 1'b1, sp, ep, h, 8'd200, 8'd200, m);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0, 8'd0, 1'b0);
  endtask
  task automatic chk_box(input logic f, input int x0, input int x1, input int y0, input int y1, input int c);
    chk("bbox_found", bbox_found, f);
    chk("x_min", x_min, x0);
    chk("x_max", x_max, x1);
    chk("y_min", y_min, y0);
    chk("y_max", y_max, y1);
    chk("pix_count", pix_count, c);
  endtask
  task automatic chk_zero();
    chk("rst_mask", mask, 0);
    chk("rst_mask_valid", mask_valid, 0);
    chk("rst_bbox_valid", bbox_valid, 0);
    chk_box(1'b0, 0, 0, 0, 0, 0);
  endtask
  task automatic frame32();
    for (int i = 0; i < 32; i++) begin
      logic m;
      m = (i == 10 || i == 13 || i == 19);
      beat(i == 0, i == 31, m ? 9'd120 : 9'd0, m);
    end
    idle();
    idle();
    chk_box(1'b1, 2, 5, 1, 2, 3);
    idle();
  endtask
  initial begin
    rst = 1'b1;
    {valid_in, sop, eop} = '0;
    hsv_h = '0;
    hsv_s = '0;
    hsv_v = '0;
    h_min = 9'd100;
    h_max = 9'd140;
    s_min = 8'd50;
    v_min = 8'd50;
    @(negedge clk);
    @(negedge clk);
    chk_zero();
    rst = 1'b0;
    frame32();
    for (int i = 0; i < 10; i++) beat(i == 0, 1'b0, (i == 3 || i == 9) ? 9'd120 : 9'd0, i == 3 || i == 9);
    @(negedge clk);
    rst = 1'b1;
    valid_in = 1'b0;
    #1;
    chk_zero();
    @(negedge clk);
    chk_zero();
    rst = 1'b0;
    pv = 1'b0;
    pe1 = 1'b0;
    pe2 = 1'b0;
    idle();
    idle();
    idle();
    frame32();
    h_min = 9'd340;
    h_max = 9'd20;
    beat(1'b1, 1'b0, 9'd350, 1'b1);
    beat(1'b0, 1'b0, 9'd5, 1'b1);
    beat(1'b0, 1'b0, 9'd21, 1'b0);
    beat(1'b0, 1'b0, 9'd339, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 9'd350, 8'd49, 8'd200, 1'b0);
    beat(1'b0, 1'b0, 9'd340, 1'b1);
    beat(1'b0, 1'b0, 9'd20, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 9'd350, 8'd200, 8'd49, 1'b0);
    idle();
    idle();
    chk_box(1'b1, 0, 6, 0, 0, 4);
    h_min = 9'd100;
    h_max = 9'd140;
    beat(1'b1, 1'b0, 9'd0, 1'b0);
    beat(1'b0, 1'b0, 9'd0, 1'b0);
    beat(1'b0, 1'b0, 9'd120, 1'b1);
    beat(1'b0, 1'b1, 9'd0, 1'b0);
    idle();
    idle();
    chk_box(1'b0, 0, 0, 0, 0, 1);
    beat(1'b1, 1'b0, 9'd0, 1'b0);
    idle();
    h_max = 9'd110;
    beat(1'b0, 1'b0, 9'd120, 1'b1);
    idle();
    idle();
    beat(1'b0, 1'b0, 9'd0, 1'b0);
    beat(1'b0, 1'b0, 9'd0, 1'b0);
    idle();
    idle();
    idle();
    beat(1'b0, 1'b0, 9'd130, 1'b1);
    beat(1'b0, 1'b0, 9'd0, 1'b0);
    beat(1'b0, 1'b0, 9'd0, 1'b0);
    beat(1'b0, 1'b0, 9'd0, 1'b0);
    idle();
    beat(1'b0, 1'b0, 9'd0, 1'b0);
    idle();
    idle();
    beat(1'b0, 1'b1, 9'd135, 1'b1);
    idle();
    idle();
    chk_box(1'b1, 1, 4, 0, 1, 3);
    h_max = 9'd140;
    beat(1'b1, 1'b0, 9'd0, 1'b0);
    beat(1'b0, 1'b0, 9'd120, 1'b1);
    beat(1'b0, 1'b0, 9'd120, 1'b1);
    beat(1'b1, 1'b1, 9'd120, 1'b1);
    idle();
    idle();
    chk_box(1'b0, 0, 0, 0, 0, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 9'd120, 8'd200, 8'd200, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 9'd120, 8'd200, 8'd200, 1'b0);
    idle();
    idle();
    idle();
    chk("hold_pix_count", pix_count, 1);
    for (int i = 0; i < 40; i++) beat(i == 0, i == 39, (i == 31 || i == 39) ? 9'd120 : 9'd0, i == 31 || i == 39);
    idle();
    idle();
    chk_box(1'b1, 7, 7, 3, 3, 2);
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
